// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, ROB id constants and opcode decode used across the CPU
package cpu_pkg;
    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int REG_W = 5;
    localparam int ROB_W = 5;
    localparam logic [ROB_W-1:0] ROB_ID_NONE = '0;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcode_e;

    // Branches and stores are the only opcodes here without a destination register
    function automatic logic has_rd(input logic [6:0] op);
        return !(op == OP_BRANCH || op == OP_STORE);
    endfunction
endpackage

// File: rtl/register_file_if.sv
// register_file_if: ROB-to-register-file bus carrying launch, commit and dependency queries
interface register_file_if;
    import cpu_pkg::*;
    logic             rdy_in;
    logic             clear_in;
    logic             launch_ready;
    logic [ROB_W-1:0] launch_rob_id;
    logic [REG_W-1:0] launch_register_id;
    logic             commit_ready;
    logic [ROB_W-1:0] commit_rob_id;
    logic [REG_W-1:0] commit_register_id;
    logic [XLEN-1:0]  commit_value;
    logic [REG_W-1:0] ask_rd_1;
    logic [REG_W-1:0] ask_rd_2;
    logic [ROB_W-1:0] dep_rd_1;
    logic [ROB_W-1:0] dep_rd_2;
    logic [XLEN-1:0]  dep_value_1;
    logic [XLEN-1:0]  dep_value_2;

    modport master (
        output rdy_in, clear_in, launch_ready, launch_rob_id, launch_register_id,
        output commit_ready, commit_rob_id, commit_register_id, commit_value,
        output ask_rd_1, ask_rd_2,
        input  dep_rd_1, dep_rd_2, dep_value_1, dep_value_2
    );

    modport slave (
        input  rdy_in, clear_in, launch_ready, launch_rob_id, launch_register_id,
        input  commit_ready, commit_rob_id, commit_register_id, commit_value,
        input  ask_rd_1, ask_rd_2,
        output dep_rd_1, dep_rd_2, dep_value_1, dep_value_2
    );
endinterface

// File: rtl/register_file_reg_query_port.sv
// reg_query_port: one combinational dependency query with x0 masking and commit bypass
module reg_query_port
    import cpu_pkg::*;
(
    input  logic [REG_W-1:0] ask,
    input  logic [ROB_W-1:0] tag,
    input  logic [XLEN-1:0]  value,
    input  logic             commit_en,
    input  logic [ROB_W-1:0] commit_rob_id,
    input  logic [REG_W-1:0] commit_register_id,
    input  logic [XLEN-1:0]  commit_value,
    output logic [ROB_W-1:0] dep_rd,
    output logic [XLEN-1:0]  dep_value
);
    logic zero;
    logic bypass;

    // A commit from the producer currently named by the tag resolves the dependency this cycle
    always_comb begin
        zero      = ask == '0;
        bypass    = commit_en && commit_register_id == ask && !zero && tag == commit_rob_id;
        dep_rd    = (zero || bypass) ? ROB_ID_NONE : tag;
        dep_value = zero ? '0 : bypass ? commit_value : value;
    end
endmodule

// File: rtl/register_file.sv
// register_file: architectural registers plus rename tags naming each register's pending ROB producer
module register_file
    import cpu_pkg::*;
(
    input logic          clk_in,
    input logic          rst_in,
    register_file_if.slave bus
);
    logic [XLEN-1:0]  regs [NREG];
    logic [ROB_W-1:0] tags [NREG];
    logic             commit_wr;
    logic             launch_wr;

    // x0 is never written, so its reset zero is permanent
    always_comb begin
        commit_wr = bus.commit_ready && bus.commit_register_id != '0;
        launch_wr = bus.launch_ready && bus.launch_register_id != '0 && !bus.clear_in;
    end

    // Later assignments win: commit's tag clear, then flush, then a launch overriding both
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
                tags[i] <= ROB_ID_NONE;
            end
        end else if (bus.rdy_in) begin
            if (commit_wr) begin
                regs[bus.commit_register_id] <= bus.commit_value;
                if (tags[bus.commit_register_id] == bus.commit_rob_id)
                    tags[bus.commit_register_id] <= ROB_ID_NONE;
            end
            if (bus.clear_in)
                for (int i = 0; i < NREG; i++)
                    tags[i] <= ROB_ID_NONE;
            if (launch_wr)
                tags[bus.launch_register_id] <= bus.launch_rob_id;
        end
    end

    reg_query_port q1 (
        .ask(bus.ask_rd_1), .tag(tags[bus.ask_rd_1]), .value(regs[bus.ask_rd_1]),
        .commit_en(bus.commit_ready && bus.rdy_in), .commit_rob_id(bus.commit_rob_id),
        .commit_register_id(bus.commit_register_id), .commit_value(bus.commit_value),
        .dep_rd(bus.dep_rd_1), .dep_value(bus.dep_value_1)
    );

    reg_query_port q2 (
        .ask(bus.ask_rd_2), .tag(tags[bus.ask_rd_2]), .value(regs[bus.ask_rd_2]),
        .commit_en(bus.commit_ready && bus.rdy_in), .commit_rob_id(bus.commit_rob_id),
        .commit_register_id(bus.commit_register_id), .commit_value(bus.commit_value),
        .dep_rd(bus.dep_rd_2), .dep_value(bus.dep_value_2)
    );
endmodule
